stream_demux: RTL and testbench
===============================

Name: stream_demux

Overview:
- Handshaked 1-to-N stream demultiplexer; the distribution-side counterpart of mux_parametric.
- Routes each accepted input word to the output channel chosen by sel_i.
- Each output channel has a one-entry registered slot, so outputs are glitch-free and every channel has its own backpressure.
- Sits between a single producer and N independent consumers.

Parameters:
- WIDTH, default mux_pkg::WIDTH (8): data word width in bits.
- N, default mux_pkg::N (4): number of output channels; N >= 2, need not be a power of two.

Ports:
- clk_i  input  1  clock; all logic on the rising edge.
- rst_i  input  1  reset; synchronous, active-high.
- demux_i  input  WIDTH  input data word.
- sel_i  input  $clog2(N)  destination channel index; sampled only on accept.
- valid_i  input  1  input word valid.
- ready_o  output  1  block can accept the word this cycle.
- demux_o  output  WIDTH x [N] (unpacked array)  per-channel output data.
- valid_o  output  N  per-channel output valid.
- ready_i  input  N  per-channel consumer ready.
- err_o  output  1  one-cycle pulse when a word with sel_i >= N is accepted and dropped.

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - valid_o = 0, demux_o[k] = 0 for all k, err_o = 0.
  - Slot contents are discarded, including reset asserted mid-transfer.
  - ready_o is 0 while rst_i=1.
- Slot state per channel k: EMPTY (valid_o[k]=0) or FULL (valid_o[k]=1).
- Input accept = valid_i && ready_o.
- ready_o is combinational:
  - sel_i >= N: ready_o = 1 (word is dropped).
  - Otherwise: ready_o = !valid_o[sel_i] || ready_i[sel_i].
  - ready_o is not a function of valid_i.
- Output drain on channel k = valid_o[k] && ready_i[k].
- Slot transitions on a clock edge:
  - EMPTY, accept with sel=k: load demux_i into the slot, go FULL.
  - FULL, drain and no accept: go EMPTY; data holds its last value.
  - FULL, drain and accept with sel=k in the same cycle: reload the new word, stay FULL; no bubble, valid_o[k] stays 1.
  - FULL, no drain: hold; demux_o[k] and valid_o[k] must be stable.
- Latency: word accepted at edge t appears on valid_o/demux_o after edge t (1 cycle).
- Throughput: 1 word/cycle per channel when the consumer holds ready_i high.
- Channels are independent: a stalled channel blocks the input only when sel_i targets that channel (head-of-line blocking by design); other FULL channels keep draining.
- Input protocol: once valid_i is high, the producer holds demux_i and sel_i stable until accept. The block does not check this; the bench asserts it.
- Output protocol: once valid_o[k] is high, it stays high with stable demux_o[k] until drain.
- Invalid select: sel_i >= N (only possible when N is not a power of two) is accepted with ready_o=1, the data is dropped, and err_o pulses for 1 cycle after the edge. No slot changes.
- Ordering: words to the same channel leave in acceptance order.

Decomposition:
- mux_pkg gains SEL_W = $clog2(N); the existing WIDTH and N are reused.
- The per-channel slot is a natural sub-module: demux_slot (one-entry valid/ready register, WIDTH param).
- stream_demux instantiates N copies of demux_slot via a generate loop, plus the select/ready decode.

Test Plan:
- Reset, then idle: valid_o=0, demux_o all 0, ready_o=1, err_o=0.
- ready_i='1; send 0xA0..0xA3 with sel=0..3 on back-to-back cycles -> each valid_o[k] high 1 cycle after its accept with demux_o[k]=0xA0+k; ready_o never low.
- ready_i[2]=0; send 0x11 then 0x22 to sel=2 -> 0x11 held on channel 2, ready_o low for the second word; raise ready_i[2] -> same-cycle drain+reload, then 0x22 appears with valid_o[2] continuously high.
- Channel 1 stalled and FULL; send 0x55 to sel=3 -> accepted; demux_o[3]=0x55 next cycle; channel 1 unchanged.
- N=3: send 0x77 with sel=3 -> ready_o=1, err_o pulses 1 cycle, all valid_o stay 0.
- Channels 0 and 2 FULL and stalled, assert rst_i for 1 cycle -> all valid_o=0, demux_o=0, and the previously buffered words never appear.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared parameters and types for the stream mux/demux family.
package mux_pkg;

   localparam int WIDTH = 8;
   localparam int N     = 4;

   // Select width for an n-channel block; never below one bit so the port exists.
   function automatic int selWidth(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int SEL_W = selWidth(N);

   // Occupancy of a one-entry output slot.
   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_state_e;

endpackage

// File: rtl/demux_slot.sv
// One-entry valid/ready output register for a single demux channel.
// load_i is already qualified by the parent (accepted word aimed at this
// channel), so the slot only decides how that combines with its own drain.
module demux_slot #(
   parameter int WIDTH = mux_pkg::WIDTH
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             ready_i,
   output logic             valid_o,
   output logic [WIDTH-1:0] data_o
);

   import mux_pkg::*;

   slot_state_e      state_q, state_d;
   logic [WIDTH-1:0] data_q, data_d;

   // State and data registers; reset empties the slot and clears the word.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= SLOT_EMPTY;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
      end
   end

   // A load always wins (reload while draining keeps valid high with no bubble);
   // otherwise a full slot empties on drain and keeps its last data.
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      case (state_q)
         SLOT_EMPTY: begin
            if (load_i) begin
               state_d = SLOT_FULL;
               data_d  = data_i;
            end
         end
         SLOT_FULL: begin
            if (load_i) begin
               data_d = data_i;
            end else if (ready_i) begin
               state_d = SLOT_EMPTY;
            end
         end
      endcase
   end

   assign valid_o = (state_q == SLOT_FULL);
   assign data_o  = data_q;

endmodule

// File: rtl/stream_demux.sv
// Handshaked 1-to-N stream demultiplexer with a registered slot per channel.
// Each channel has its own backpressure; the input stalls only when the
// selected channel is full and not draining. Out-of-range selects are
// accepted, dropped and flagged on err_o.
module stream_demux #(
   parameter  int WIDTH = mux_pkg::WIDTH,
   parameter  int N     = mux_pkg::N,
   localparam int SelW  = mux_pkg::selWidth(N)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] demux_i,
   input  logic [SelW-1:0]  sel_i,
   input  logic             valid_i,
   output logic             ready_o,
   output logic [WIDTH-1:0] demux_o [N],
   output logic [N-1:0]     valid_o,
   input  logic [N-1:0]     ready_i,
   output logic             err_o
);

   import mux_pkg::*;

   localparam logic [SelW:0] NumCh = (SelW + 1)'(N);

   logic selValid;
   logic targetReady;
   logic accept;
   logic err_q, err_d;

   assign selValid = ({1'b0, sel_i} < NumCh);

   // Readiness of the addressed channel: free now, or being drained this cycle.
   always_comb begin
      targetReady = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (sel_i == SelW'(k)) begin
            targetReady = !valid_o[k] || ready_i[k];
         end
      end
   end

   assign ready_o = !rst_i && (!selValid || targetReady);
   assign accept  = valid_i && ready_o;

   // A dropped word raises the error flag for the cycle after its accept.
   always_comb begin
      err_d = accept && !selValid;
   end

   // Error pulse register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign err_o = err_q;

   for (genvar k = 0; k < N; k++) begin : gSlot
      demux_slot #(
         .WIDTH (WIDTH)
      ) uSlot (
         .clk_i   (clk_i),
         .rst_i   (rst_i),
         .load_i  (accept && selValid && (sel_i == SelW'(k))),
         .data_i  (demux_i),
         .ready_i (ready_i[k]),
         .valid_o (valid_o[k]),
         .data_o  (demux_o[k])
      );
   end

endmodule

// File: tb/tb_stream_demux.sv
// Self-checking bench for stream_demux: a 4-channel instance driven through
// directed and random traffic against a queue scoreboard, plus a 3-channel
// instance for the out-of-range select path.
module tb_stream_demux;

   typedef struct {
      int         ch;
      logic [7:0] data;
   } exp_t;

   logic       clk;
   logic       rst;

   logic [7:0] dIn;
   logic [1:0] sel;
   logic       vIn;
   logic [3:0] rdy;
   logic       readyOut;
   logic [7:0] demuxOut [4];
   logic [3:0] validOut;
   logic       errOut;

   logic [7:0] d3;
   logic [1:0] sel3;
   logic       v3;
   logic [2:0] rdy3;
   logic       ready3;
   logic [7:0] demux3 [3];
   logic [2:0] valid3;
   logic       err3;

   exp_t expQ [$];
   int   checkCount = 0;
   int   passCount  = 0;
   bit   lastAccepted = 1'b0;

   stream_demux #(.WIDTH(8), .N(4)) dut4 (
      .clk_i   (clk),
      .rst_i   (rst),
      .demux_i (dIn),
      .sel_i   (sel),
      .valid_i (vIn),
      .ready_o (readyOut),
      .demux_o (demuxOut),
      .valid_o (validOut),
      .ready_i (rdy),
      .err_o   (errOut)
   );

   stream_demux #(.WIDTH(8), .N(3)) dut3 (
      .clk_i   (clk),
      .rst_i   (rst),
      .demux_i (d3),
      .sel_i   (sel3),
      .valid_i (v3),
      .ready_o (ready3),
      .demux_o (demux3),
      .valid_o (valid3),
      .ready_i (rdy3),
      .err_o   (err3)
   );

   // Free-running 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checkCount++;
      assert (obs === exp) passCount++;
      else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic int findCh(input int k);
      for (int i = 0; i < expQ.size(); i++) begin
         if (expQ[i].ch == k) return i;
      end
      return -1;
   endfunction

   task automatic applyStimulus(input logic [7:0] d, input logic [1:0] s, input logic v, input logic [3:0] r);
      dIn = d;
      sel = s;
      vIn = v;
      rdy = r;
   endtask

   // One clock of the 4-channel instance: compare slots and ready_o against the
   // scoreboard at the falling edge, retire drains, record accepts, then clock.
   task automatic stepCycle();
      int  idx;
      bit  modelReady;
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         idx = findCh(k);
         checkOutput($sformatf("valid_o[%0d]", k), 32'(validOut[k]), 32'(idx >= 0));
         if (idx >= 0) begin
            checkOutput($sformatf("demux_o[%0d]", k), 32'(demuxOut[k]), 32'(expQ[idx].data));
         end
      end
      checkOutput("err_o", 32'(errOut), 32'd0);
      modelReady = !rst && ((findCh(int'(sel)) < 0) || rdy[sel]);
      checkOutput("ready_o", 32'(readyOut), 32'(modelReady));
      for (int k = 0; k < 4; k++) begin
         idx = findCh(k);
         if (idx >= 0 && rdy[k]) expQ.delete(idx);
      end
      lastAccepted = vIn && modelReady;
      if (lastAccepted) expQ.push_back('{ch: int'(sel), data: dIn});
      @(posedge clk);
      #1;
      if (rst) expQ.delete();
   endtask

   initial begin
      rst = 1'b1;
      applyStimulus(8'h00, 2'd0, 1'b0, 4'h0);
      d3 = 8'h00; sel3 = 2'd0; v3 = 1'b0; rdy3 = 3'b111;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // Reset state and idle.
      for (int k = 0; k < 4; k++) checkOutput($sformatf("rst demux_o[%0d]", k), 32'(demuxOut[k]), 32'd0);
      checkOutput("rst valid_o", 32'(validOut), 32'd0);
      checkOutput("rst err_o", 32'(errOut), 32'd0);
      checkOutput("rst valid3", 32'(valid3), 32'd0);
      stepCycle();

      // Back-to-back words to every channel with all consumers ready.
      for (int k = 0; k < 4; k++) begin
         applyStimulus(8'hA0 + 8'(k), 2'(k), 1'b1, 4'hF);
         stepCycle();
      end
      applyStimulus(8'h00, 2'd0, 1'b0, 4'hF);
      stepCycle();
      stepCycle();

      // Stall channel 2, fill it, backpressure the second word, then release.
      applyStimulus(8'h11, 2'd2, 1'b1, 4'b1011);
      stepCycle();
      applyStimulus(8'h22, 2'd2, 1'b1, 4'b1011);
      stepCycle();
      stepCycle();
      applyStimulus(8'h22, 2'd2, 1'b1, 4'hF);
      stepCycle();
      applyStimulus(8'h00, 2'd0, 1'b0, 4'hF);
      stepCycle();

      // Channel 1 full and stalled must not block traffic to channel 3.
      applyStimulus(8'h33, 2'd1, 1'b1, 4'b1101);
      stepCycle();
      applyStimulus(8'h55, 2'd3, 1'b1, 4'b0101);
      stepCycle();
      applyStimulus(8'h00, 2'd0, 1'b0, 4'b1101);
      stepCycle();
      checkOutput("ch3 word", 32'(demuxOut[3]), 32'h55);

      // Fill channels 0 and 2 while stalled, then reset mid-transfer.
      applyStimulus(8'h66, 2'd0, 1'b1, 4'b0000);
      stepCycle();
      applyStimulus(8'h88, 2'd2, 1'b1, 4'b0000);
      stepCycle();
      applyStimulus(8'h00, 2'd0, 1'b0, 4'b0000);
      rst = 1'b1;
      stepCycle();
      rst = 1'b0;
      for (int k = 0; k < 4; k++) checkOutput($sformatf("mid-rst demux_o[%0d]", k), 32'(demuxOut[k]), 32'd0);
      checkOutput("mid-rst valid_o", 32'(validOut), 32'd0);
      applyStimulus(8'h00, 2'd0, 1'b0, 4'hF);
      stepCycle();
      stepCycle();

      // Random traffic; inputs change only after the pending word is accepted.
      for (int i = 0; i < 40; i++) begin
         if (lastAccepted || !vIn) begin
            dIn = 8'($urandom);
            sel = 2'($urandom_range(0, 3));
            vIn = 1'($urandom_range(0, 1));
         end
         rdy = 4'($urandom);
         stepCycle();
      end
      applyStimulus(8'h00, 2'd0, 1'b0, 4'hF);
      stepCycle();
      stepCycle();
      checkOutput("scoreboard empty", 32'(expQ.size()), 32'd0);

      // Three-channel instance: an out-of-range select is dropped and flagged.
      v3 = 1'b1; sel3 = 2'd3; d3 = 8'h77;
      #1;
      checkOutput("n3 ready bad sel", 32'(ready3), 32'd1);
      @(posedge clk);
      #1;
      v3 = 1'b0;
      checkOutput("n3 err pulse", 32'(err3), 32'd1);
      checkOutput("n3 valid after drop", 32'(valid3), 32'd0);
      @(posedge clk);
      #1;
      checkOutput("n3 err cleared", 32'(err3), 32'd0);
      checkOutput("n3 valid idle", 32'(valid3), 32'd0);
      v3 = 1'b1; sel3 = 2'd1; d3 = 8'h42;
      @(posedge clk);
      #1;
      v3 = 1'b0;
      checkOutput("n3 valid ch1", 32'(valid3), 32'b010);
      checkOutput("n3 data ch1", 32'(demux3[1]), 32'h42);
      checkOutput("n3 no err", 32'(err3), 32'd0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
